// File: rtl/imm_encoder.sv
// Immediate-field encoder: direct range checks for the 8/12-bit and branch
// modes, and a serial rotation search for the rotated 8-bit immediate mode.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  imm_src,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [23:0] field
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_U8     = 2'b00,
        MODE_U12    = 2'b01,
        MODE_BRANCH = 2'b10,
        MODE_ROT    = 2'b11
    } mode_t;

    state_t      state;
    logic [3:0]  rot_cnt;
    logic [31:0] val_q;

    logic        direct_valid;
    logic [23:0] direct_field;
    logic [4:0]  rot_amt;
    logic [63:0] rot_dbl;
    logic [31:0] rotated;
    logic        rot_match;

    // Single-cycle encodings, evaluated on the live inputs in the accept cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        direct_valid = 1'b0;
        direct_field = '0;
        case (mode_t'(imm_src))
            MODE_U8: begin
                direct_valid = (value[31:8] == '0);
                direct_field = {16'b0, value[7:0]};
            end
            MODE_U12: begin
                direct_valid = (value[31:12] == '0);
                direct_field = {12'b0, value[11:0]};
            end
            MODE_BRANCH: begin
                direct_valid = (value[1:0] == 2'b00) &&
                               ((value[31:25] == '0) || (value[31:25] == '1));
                direct_field = value[25:2];
            end
            default: begin
                direct_valid = 1'b0;
                direct_field = '0;
            end
        endcase
    end

    // Rotate left by 2*r: shift a doubled copy and keep the upper word.
    assign rot_amt   = {rot_cnt, 1'b0};
    assign rot_dbl   = {val_q, val_q} << rot_amt;
    assign rotated   = rot_dbl[63:32];
    assign rot_match = (rotated[31:8] == '0);

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rot_cnt <= '0;
            val_q   <= '0;
            done    <= 1'b0;
            valid   <= 1'b0;
            field   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        val_q   <= value;
                        rot_cnt <= '0;
                        if (mode_t'(imm_src) == MODE_ROT) begin
                            state <= SEARCH;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            valid <= direct_valid;
                            field <= direct_valid ? direct_field : '0;
                        end
                    end
                end
                SEARCH: begin
                    if (rot_match) begin
                        state <= DONE;
                        done  <= 1'b1;
                        valid <= 1'b1;
                        field <= {12'b0, rot_cnt, rotated[7:0]};
                    end else if (rot_cnt == 4'd15) begin
                        state <= DONE;
                        done  <= 1'b1;
                        valid <= 1'b0;
                        field <= '0;
                    end else begin
                        rot_cnt <= rot_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed-vector bench for imm_encoder: latency, result, hold and reset-abort checks.
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  imm_src;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        valid;
    logic [23:0] field;

    int n_vec  = 0;
    int n_miss = 0;

    imm_encoder dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .imm_src (imm_src),
        .value   (value),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .field   (field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, optionally pulse a stray start at cycle glitch_at,
    // and check latency, result, busy coverage and post-completion hold.
    task automatic run(input string tag, input logic [1:0] mode, input logic [31:0] val,
                       input int exp_lat, input logic exp_valid, input logic [23:0] exp_field,
                       input int glitch_at);
        int          n;
        logic        busy_all;
        logic        got_valid;
        logic [23:0] got_field;
        @(negedge clk);
        start   = 1'b1;
        imm_src = mode;
        value   = val;
        @(negedge clk);
        start   = 1'b0;
        value   = 32'hA5A5_A5A5;
        imm_src = ~mode;
        n        = 1;
        busy_all = 1'b1;
        while (1) begin
            if (!busy) busy_all = 1'b0;
            if (n == glitch_at) begin
                start   = 1'b1;
                imm_src = 2'b00;
                value   = 32'h0000_0011;
            end else begin
                start = 1'b0;
            end
            if (done || n >= 40) break;
            @(negedge clk);
            n++;
        end
        got_valid = valid;
        got_field = field;
        check({tag, ":latency"}, n, exp_lat);
        check({tag, ":valid"}, {31'b0, got_valid}, {31'b0, exp_valid});
        check({tag, ":field"}, {8'b0, got_field}, {8'b0, exp_field});
        check({tag, ":busy"}, {31'b0, busy_all}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check({tag, ":idle_busy"}, {31'b0, busy}, 32'd0);
        check({tag, ":idle_done"}, {31'b0, done}, 32'd0);
        check({tag, ":hold_field"}, {8'b0, field}, {8'b0, exp_field});
        check({tag, ":hold_valid"}, {31'b0, valid}, {31'b0, exp_valid});
    endtask

    initial begin
        logic saw_done;

        reset   = 1'b1;
        start   = 1'b0;
        imm_src = 2'b00;
        value   = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst:busy",  {31'b0, busy},  32'd0);
        check("rst:done",  {31'b0, done},  32'd0);
        check("rst:valid", {31'b0, valid}, 32'd0);
        check("rst:field", {8'b0, field},  32'd0);

        run("m11_ff",       2'b11, 32'h0000_00FF,  2, 1'b1, 24'h0000FF, 0);
        run("m11_ff000000", 2'b11, 32'hFF00_0000,  6, 1'b1, 24'h0004FF, 0);
        run("m11_101",      2'b11, 32'h0000_0101, 17, 1'b0, 24'h000000, 0);
        run("m10_neg",      2'b10, 32'hFFFF_FFF8,  1, 1'b1, 24'hFFFFFE, 0);
        run("m10_unalign",  2'b10, 32'h0000_0006,  1, 1'b0, 24'h000000, 0);
        run("m10_range",    2'b10, 32'h0200_0000,  1, 1'b0, 24'h000000, 0);
        run("m10_maxpos",   2'b10, 32'h01FF_FFFC,  1, 1'b1, 24'h7FFFFF, 0);
        run("m00_over",     2'b00, 32'h0000_0100,  1, 1'b0, 24'h000000, 0);
        run("m01_max",      2'b01, 32'h0000_0FFF,  1, 1'b1, 24'h000FFF, 0);
        run("m01_over",     2'b01, 32'h0000_1000,  1, 1'b0, 24'h000000, 0);
        run("m11_zero",     2'b11, 32'h0000_0000,  2, 1'b1, 24'h000000, 0);
        run("m00_done_st",  2'b00, 32'h0000_00AB,  1, 1'b1, 24'h0000AB, 1);
        run("m11_glitch",   2'b11, 32'hFF00_0000,  6, 1'b1, 24'h0004FF, 3);
        run("m11_r15",      2'b11, 32'h0000_03FC, 17, 1'b1, 24'h000FFF, 0);
        run("m11_r1",       2'b11, 32'h8000_0001,  3, 1'b1, 24'h000106, 0);

        // Abort a failing search with reset at t+5; no Done may follow.
        @(negedge clk);
        start   = 1'b1;
        imm_src = 2'b11;
        value   = 32'h0000_0101;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort:busy",  {31'b0, busy},  32'd0);
        check("abort:done",  {31'b0, done},  32'd0);
        check("abort:valid", {31'b0, valid}, 32'd0);
        check("abort:field", {8'b0, field},  32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort:no_done", {31'b0, saw_done}, 32'd0);

        // Start coincident with reset is ignored.
        reset   = 1'b1;
        start   = 1'b1;
        imm_src = 2'b00;
        value   = 32'h0000_0005;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start:busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("rst_start:done", {31'b0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 Start  input  1  request pulse; accepted only when Busy=0.
REQ-004 ImmSrc  input  2  encoding mode: 00 unsigned 8-bit, 01 unsigned 12-bit, 10 24-bit signed word-shifted branch, 11 rotated 8-bit immediate (imm8 + rot4).
REQ-005 Value  input  32  32-bit immediate or byte offset to encode; sampled with ImmSrc on the accepted Start cycle.
REQ-006 Busy  output  1  high while a request is in progress (state SEARCH or DONE).
REQ-007 Done  output  1  one-cycle completion pulse.
REQ-008 Valid  output  1  result encodable; meaningful when Done=1, held until next completion.
REQ-009 Field  output  24  encoded instruction field; zero-extended to 24 bits for modes 00/01/11.

Function
REQ-010 States: IDLE, SEARCH, DONE; Busy = (state != IDLE).
REQ-011 IDLE + Start=1: latch Value and ImmSrc; modes 00/01/10 -> DONE; mode 11 -> SEARCH with rotation counter r=0.
REQ-012 Start while Busy=1 (including the DONE cycle) is ignored; latched operands are unaffected by later Value/ImmSrc changes.
REQ-013 Mode 00: Valid = (Value[31:8]==0); Field = {16'b0, Value[7:0]}.
REQ-014 Mode 01: Valid = (Value[31:12]==0); Field = {12'b0, Value[11:0]}.
REQ-015 Mode 10: Valid = (Value[1:0]==0) and Value[31:25] all equal; Field = Value[25:2].
REQ-016 Mode 11, SEARCH: each cycle compute R = Value rotated left by 2*r; match when R[31:8]==0.
REQ-017 SEARCH match: register Valid=1, Field = {12'b0, r[3:0], R[7:0]}, go to DONE; the smallest matching r wins.
REQ-018 SEARCH no match with r<15: r increments by 1, stay in SEARCH.
REQ-019 SEARCH no match with r==15: register Valid=0, Field=0, go to DONE.
REQ-020 Every non-encodable result in any mode drives Field=0 and Valid=0.
REQ-021 DONE: Done=1 for exactly one cycle, then IDLE unconditionally.
REQ-022 Latency from accepted Start at cycle t: modes 00/01/10 Done at t+1; mode 11 with match at r=k Done at t+2+k; mode 11 failure Done at t+17.
REQ-023 Valid and Field update only on entry to DONE and hold their values through IDLE until the next completion.
REQ-024 Value=0 in mode 11 matches at r=0: Field=0, Valid=1, Done at t+2.

Reset
REQ-025 reset=1: next state IDLE, r=0, Busy=0, Done=0, Valid=0, Field=0, latched operands=0.
REQ-026 reset takes priority over Start and over any in-progress SEARCH or DONE; an aborted request produces no Done pulse.
REQ-027 Start asserted in the same cycle as reset is ignored.

Verification
REQ-028 Mode 11, Value=0x000000FF, Start at t -> Done at t+2, Valid=1, Field=0x0000FF.
REQ-029 Mode 11, Value=0xFF000000 -> match at r=4, Done at t+6, Valid=1, Field=0x0004FF; Busy high t+1..t+6.
REQ-030 Mode 11, Value=0x00000101 -> Done at t+17, Valid=0, Field=0x000000.
REQ-031 Mode 10, Value=0xFFFFFFF8 -> Done at t+1, Valid=1, Field=0xFFFFFE.
REQ-032 Mode 10, Value=0x00000006 -> Valid=0, Field=0.
REQ-033 Mode 10, Value=0x02000000 -> Valid=0, Field=0.
REQ-034 Mode 00, Value=0x00000100 -> Valid=0, Field=0.
REQ-035 Mode 01, Value=0x00000FFF -> Valid=1, Field=0x000FFF.
REQ-036 Mode 11, Value=0x00000101, reset at t+5 -> Busy=0 and Done=0 from t+6; no Done pulse for the aborted request.
REQ-037 Start pulsed at t+3 during a search -> ignored; original result and timing unchanged.
